ahb_vh_mst: RTL
===============

# ahb_vh_mst

Single-outstanding AHB-Lite master that turns a level-based valid/hold client request into one AHB-Lite SINGLE transfer. It is the initiator-side counterpart of the AHB slave interface that fronts the crypto register blocks. It lets firmware-less engines such as DMA helpers and key loaders drive the same AHB fabric. Each request runs one address phase and one data phase, then returns read data and error status to the client.

## Interface
Parameters:
- AHB_ADDR_WIDTH, default 32: haddr/addr_i width.
- AHB_DATA_WIDTH, default 32: hwdata/hrdata width. Only 32 is supported.
- TIMEOUT_CYCLES, default 256: stall limit, used only with the timeout feature.

Ports (clock and reset):
- clk  in  1  Clock. Everything is rising-edge.
- rst  in  1  Asynchronous, active-high reset.

Ports (AHB master side):
- haddr_o  out  AHB_ADDR_WIDTH  Transfer address.
- htrans_o  out  2  Transfer type: IDLE (2'b00) or NONSEQ (2'b10) only.
- hwrite_o  out  1  1 = write.
- hsize_o  out  3  Transfer size.
- hburst_o  out  3  Tied to 3'b000 (SINGLE).
- hwdata_o  out  AHB_DATA_WIDTH  Write data, valid during the data phase.
- hready_i  in  1  Bus ready.
- hresp_i  in  1  1 = ERROR.
- hrdata_i  in  AHB_DATA_WIDTH  Read data.

Ports (client side):
- dv_i  in  1  Request valid, level. Fields are sampled when the request is accepted.
- write_i  in  1  Request direction, 1 = write.
- addr_i  in  AHB_ADDR_WIDTH  Request address.
- size_i  in  3  Request size. 0, 1 and 2 are legal.
- wdata_i  in  AHB_DATA_WIDTH  Write data, already placed on the correct byte lanes.
- hld_o  out  1  Busy. High whenever the FSM is not in IDLE.
- done_o  out  1  One-cycle completion pulse.
- rdata_o  out  AHB_DATA_WIDTH  Read data. Valid with done_o; holds until the next done_o.
- err_o  out  1  Error status. Valid with done_o.

## Operation
FSM states: IDLE, ADDR, DATA, ERR2, plus TOUT when the timeout feature is compiled in.

- **IDLE**
  - Accept: dv_i=1 and done_o=0. A request arriving in the done_o cycle is ignored.
  - On accept, register write_i, addr_i, size_i and wdata_i.
  - Illegal requests never reach the bus. A request is illegal if size_i>2, or if addr_i is misaligned to the size (size 1 with addr[0]=1; size 2 with addr[1:0]≠0).
  - For an illegal request: stay in IDLE and pulse done_o with err_o=1 on the next cycle.
  - For a legal request: go to ADDR.
- **ADDR**
  - Drive htrans_o=NONSEQ, haddr_o, hwrite_o and hsize_o from the captured fields.
  - When hready_i=1, go to DATA and drive htrans_o=IDLE from the next cycle.
- **DATA**
  - hwdata_o = captured wdata. Outside DATA, hwdata_o = 0.
  - hready_i=1, hresp_i=0: capture hrdata_i into rdata_o (reads only), pulse done_o with err_o=0, return to IDLE.
  - hready_i=0, hresp_i=1: first error cycle; go to ERR2.
  - hready_i=0, hresp_i=0: wait state; stay in DATA.
- **ERR2**
  - htrans_o=IDLE.
  - When hready_i=1: pulse done_o with err_o=1, leave rdata_o unchanged, return to IDLE.
- **Write completion:** rdata_o is not updated.
- **Bus timing:** exactly one transfer is outstanding; no pipelining of the next address.

## Timing
- Reset values: htrans_o=0, haddr_o=0, hwrite_o=0, hsize_o=0, hwdata_o=0, hld_o=0, done_o=0, rdata_o=0, err_o=0, FSM in IDLE.
- All outputs are registered.
- Zero-wait-state transfer, with dv_i sampled high at edge N:
  - cycle N+1: address phase, hld_o=1.
  - cycle N+2: data phase.
  - cycle N+3: done_o=1, hld_o=0.
- Each slave wait state adds one cycle.
- An ERROR response adds one cycle (ERR2).
- Back-to-back requests: the earliest next accept is edge N+4, giving a 4-cycle minimum per transfer.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The transfer is abandoned and done_o does not pulse.

## Configuration
- Macro: AHB_VH_MST_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts consecutive hready_i=0 cycles while in ADDR, DATA or ERR2. It clears whenever hready_i=1 or the FSM is in IDLE.
  - When the count reaches TIMEOUT_CYCLES, go to TOUT: htrans_o=IDLE, pulse done_o with err_o=1 on the next cycle, then IDLE.
- When undefined: no counter, no TOUT state. The FSM waits on hready_i indefinitely.

## Test plan
- Zero-wait read: addr 0x1000, size 2, hrdata=0xDEADBEEF → NONSEQ at N+1, done_o at N+3, rdata_o=0xDEADBEEF, err_o=0.
- Write with 3 wait states: addr 0x2004, wdata 0xA5A5_0000 → hwdata_o held for 4 data cycles, done_o at N+6, rdata_o unchanged.
- Two-cycle ERROR response on a read → ERR2 entered, htrans_o=IDLE, done_o with err_o=1 at N+4, rdata_o unchanged.
- Illegal request: size 2 at addr 0x3002, or size 3 → no NONSEQ ever driven, done_o with err_o=1 at N+1.
- rst pulsed while in DATA, then dv_i held high → outputs zero during reset, no done_o, fresh transfer starts normally.
- With AHB_VH_MST_TIMEOUT_EN and TIMEOUT_CYCLES=8: hready_i held low → done_o with err_o=1 exactly 9 cycles after stalling began. Without the macro → hld_o stays high.

Source files
------------

// File: rtl/ahb_vh_mst_if.sv
// AHB-Lite bus bundle between ahb_vh_mst (master modport) and the fabric/slave (slave modport).
interface ahb_vh_mst_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic [1:0]                htrans_o;
    logic                      hwrite_o;
    logic [2:0]                hsize_o;
    logic [2:0]                hburst_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic                      hready_i;
    logic                      hresp_i;
    logic [AHB_DATA_WIDTH-1:0] hrdata_i;

    modport master (
        output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o,
        input  hready_i, hresp_i, hrdata_i
    );

    modport slave (
        input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o,
        output hready_i, hresp_i, hrdata_i
    );
endinterface

// File: rtl/ahb_vh_mst.sv
// Single-outstanding AHB-Lite master: one valid/hold client request becomes one SINGLE transfer.
// Optional stall timeout (TOUT state + counter) is compiled in with AHB_VH_MST_TIMEOUT_EN.
module ahb_vh_mst #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    ahb_vh_mst_if.master              bus,
    input  logic                      dv_i,
    input  logic                      write_i,
    input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]                size_i,
    input  logic [AHB_DATA_WIDTH-1:0] wdata_i,
    output logic                      hld_o,
    output logic                      done_o,
    output logic [AHB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR2
`ifdef AHB_VH_MST_TIMEOUT_EN
        , ST_TOUT
`endif
    } state_t;

    state_t                    state_reg,  state_next;
    logic [AHB_DATA_WIDTH-1:0] wdata_reg,  wdata_next;
    logic [AHB_ADDR_WIDTH-1:0] haddr_reg,  haddr_next;
    logic                      hwrite_reg, hwrite_next;
    logic [2:0]                hsize_reg,  hsize_next;
    logic [1:0]                htrans_reg, htrans_next;
    logic [AHB_DATA_WIDTH-1:0] hwdata_reg, hwdata_next;
    logic                      hld_reg,    hld_next;
    logic                      done_reg,   done_next;
    logic                      err_reg,    err_next;
    logic [AHB_DATA_WIDTH-1:0] rdata_reg,  rdata_next;

    function automatic logic req_legal(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    req_legal = 1'b1;
            3'd1:    req_legal = ~lsb[0];
            3'd2:    req_legal = (lsb == 2'b00);
            default: req_legal = 1'b0;
        endcase
    endfunction

`ifdef AHB_VH_MST_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             stall_expire;

    // Counts consecutive not-ready cycles of an in-flight transfer; expires on the cycle it reaches the limit.
    always_comb begin
        stall_cnt_next = '0;
        stall_expire   = 1'b0;
        if ((state_reg == ST_ADDR || state_reg == ST_DATA || state_reg == ST_ERR2) && !bus.hready_i) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
            stall_expire   = (stall_cnt_reg == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end
`endif

    always_comb begin
        state_next  = state_reg;
        wdata_next  = wdata_reg;
        haddr_next  = haddr_reg;
        hwrite_next = hwrite_reg;
        hsize_next  = hsize_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        done_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A request still high during the completion pulse belongs to the finished transfer.
                if (dv_i && !done_reg) begin
                    if (req_legal(size_i, addr_i[1:0])) begin
                        state_next  = ST_ADDR;
                        wdata_next  = wdata_i;
                        haddr_next  = addr_i;
                        hwrite_next = write_i;
                        hsize_next  = size_i;
                    end else begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.hready_i) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.hready_i) begin
                    // hresp with hready high is not a legal slave response; report it as an error anyway.
                    done_next  = 1'b1;
                    err_next   = bus.hresp_i;
                    state_next = ST_IDLE;
                    if (!hwrite_reg && !bus.hresp_i) begin
                        rdata_next = bus.hrdata_i;
                    end
                end else if (bus.hresp_i) begin
                    state_next = ST_ERR2;
                end
            end
            ST_ERR2: begin
                if (bus.hready_i) begin
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`ifdef AHB_VH_MST_TIMEOUT_EN
            ST_TOUT: begin
                done_next  = 1'b1;
                err_next   = 1'b1;
                state_next = ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef AHB_VH_MST_TIMEOUT_EN
        if (stall_expire) begin
            state_next = ST_TOUT;
        end
`endif

        // Bus-facing outputs are registered from the state being entered.
        htrans_next = (state_next == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwdata_next = (state_next == ST_DATA) ? wdata_reg : '0;
        hld_next    = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            wdata_reg  <= '0;
            haddr_reg  <= '0;
            hwrite_reg <= 1'b0;
            hsize_reg  <= 3'd0;
            htrans_reg <= HTRANS_IDLE;
            hwdata_reg <= '0;
            hld_reg    <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wdata_reg  <= wdata_next;
            haddr_reg  <= haddr_next;
            hwrite_reg <= hwrite_next;
            hsize_reg  <= hsize_next;
            htrans_reg <= htrans_next;
            hwdata_reg <= hwdata_next;
            hld_reg    <= hld_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign bus.haddr_o  = haddr_reg;
    assign bus.htrans_o = htrans_reg;
    assign bus.hwrite_o = hwrite_reg;
    assign bus.hsize_o  = hsize_reg;
    assign bus.hburst_o = 3'b000;
    assign bus.hwdata_o = hwdata_reg;
    assign hld_o        = hld_reg;
    assign done_o       = done_reg;
    assign err_o        = err_reg;
    assign rdata_o      = rdata_reg;
endmodule
